i2c_master_seq: RTL
===================

// Module: i2c_master_seq
// PURPOSE
// - Transaction sequencer for the I2C master. Sits directly upstream of the address unit (AUCLK).
// - Accepts a request (addr, rw, byte count), issues go/abit/addrIn to AUCLK and muxes AUCLK's oSDA onto the bus.
// - Owns START, R/W bit, ACK sampling, data bytes (MSB first) and STOP.
// - One bus bit per clk: clk is the bit-rate clock shared with AUCLK.
// PARAMETERS
// - NB_W       4  width of byte-count input; max bytes per transaction = 2**NB_W-1
// - STOP_HOLD  1  cycles oSDA held low in STOP before release (>=1)
// PORTS
// - clk      in   1      bit-rate clock, rising edge
// - rst      in   1      asynchronous, active-low reset
// - start    in   1      request; accepted when start & ready
// - ready    out  1      1 only in IDLE
// - addr     in   7      slave address, latched on accept
// - rw       in   1      0=write, 1=read, latched on accept
// - nbytes   in   NB_W   data bytes to transfer; 0 = address-only probe
// - wdata    in   8      write byte; byte0 latched on accept, later bytes on wnext
// - wnext    out  1      1-cycle pulse: next wdata sampled this cycle
// - iSDA     in   1      sampled bus SDA (ACK / read data)
// - auSDA    in   1      oSDA from AUCLK
// - go       out  1      to AUCLK: 1-cycle load pulse
// - abit     out  1      to AUCLK: shift enable, high exactly 7 cycles
// - addrIn   out  7      to AUCLK: latched address, stable from go to end of ADDR
// - oSDA     out  1      bus SDA drive (1 = released)
// - sclEn    out  1      bus clock gate: high ADDR..DACK inclusive
// - rdata    out  8      read byte, valid with rvalid
// - rvalid   out  1      1-cycle pulse per read byte
// - done     out  1      1-cycle pulse, last STOP cycle
// - nack     out  1      sticky error: slave NACKed; cleared on next accept
// BEHAVIOUR
// - Reset (async): state=IDLE, oSDA=1, ready=1; go, abit, sclEn, wnext, rvalid, done, nack = 0; addrIn, rdata = 0.
// - IDLE:  oSDA=1. On start & ready: latch addr/rw/nbytes/wdata, go=1 (same cycle), nack=0 -> START.
// - START: oSDA=0, 1 cycle -> ADDR.
// - ADDR:  abit=1, oSDA=auSDA, bit counter 6..0, 7 cycles -> RW.
// - RW:    oSDA=rw, 1 cycle -> AACK.
// - AACK:  oSDA=1; sample iSDA.
//   - iSDA=1 -> nack=1, STOP.
//   - else nbytes==0 -> STOP.
//   - else -> DATA.
// - DATA: 8 cycles, counter 7..0.
//   - Write: oSDA=shreg[7], shift left.
//   - Read: oSDA=1; shift iSDA in at LSB each cycle.
// - DACK, remaining count decremented here:
//   - Write: oSDA=1, sample iSDA; 1 -> nack=1, STOP.
//     - else remaining>0 -> wnext=1, load wdata, DATA.
//     - else STOP.
//   - Read: rdata<=shreg, rvalid=1; oSDA=0 (ACK) if remaining>0, else 1 (NACK last byte).
//     - remaining>0 -> DATA, else STOP.
// - STOP: oSDA=0 for STOP_HOLD cycles, then 1 cycle oSDA=1 with done=1 -> IDLE.
// - Latency, accept to done (STOP_HOLD=1):
//   - 1-byte write = 22 cycles (go + 1 START + 7 ADDR + 1 RW + 1 AACK + 8 DATA + 1 DACK + 2 STOP).
//   - Each extra byte adds 9 cycles.
// - start while busy: ignored; no queuing.
// - nbytes=0: address-only probe, 13 cycles, nack reports presence.
// - Reset mid-transaction: immediate IDLE, oSDA=1; no STOP generated; counters cleared.
// - nack persists through IDLE until the next accepted start.
// CONFIGURATION
// - Macro I2C_ACK_CHECK_EN.
// - Defined: ACK checks in AACK/DACK(write) as above.
// - Undefined: iSDA ignored in AACK/DACK(write); transaction always completes all bytes; nack tied 0.
// - Read-path ACK driving is identical in both builds.
// TESTING
// - Reset low 15ns, release; idle 3 cycles -> oSDA=1, ready=1, all pulses 0.
// - Write addr=65 (7'h41), nbytes=1, wdata=8'hA5, iSDA=0 at ACK slots:
//   - go 1 cycle; abit high 7 cycles; addrIn=65; oSDA in RW=0; DATA bits 1,0,1,0,0,1,0,1.
//   - done at cycle 22; nack=0.
// - Read addr=0x50, nbytes=2; slave drives 8'h3C then 8'hC3:
//   - rvalid twice with rdata=3C, C3; DACK oSDA=0 then 1; done.
// - Probe addr=0x22, nbytes=0, iSDA=1 at AACK:
//   - nack=1 with ACK check enabled, no DATA, done at cycle 13.
//   - Without I2C_ACK_CHECK_EN: nack=0.
// - Write nbytes=3, rst low during 2nd DATA byte:
//   - oSDA=1, ready=1, sclEn=0 immediately.
//   - Next start accepted normally; start pulses during busy have no effect.

Source files
------------

// File: rtl/i2c_master_seq.sv
// i2c_master_seq: I2C transaction sequencer upstream of the AUCLK address unit.
// Optional build macro I2C_ACK_CHECK_EN enables slave ACK checking and nack.
module i2c_master_seq #(
    parameter int NB_W      = 4,
    parameter int STOP_HOLD = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            ready,
    input  logic [6:0]      addr,
    input  logic            rw,
    input  logic [NB_W-1:0] nbytes,
    input  logic [7:0]      wdata,
    output logic            wnext,
    input  logic            iSDA,
    input  logic            auSDA,
    output logic            go,
    output logic            abit,
    output logic [6:0]      addrIn,
    output logic            oSDA,
    output logic            sclEn,
    output logic [7:0]      rdata,
    output logic            rvalid,
    output logic            done,
    output logic            nack
);

    localparam int HW = $clog2(STOP_HOLD + 1) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_RW,
        S_AACK,
        S_DATA,
        S_DACK,
        S_STOP
    } state_t;

    state_t          state_q, state_d;
    logic [6:0]      addr_q, addr_d;
    logic            rw_q, rw_d;
    logic [NB_W-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      sh_q, sh_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            nack_q, nack_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            rvalid_q, rvalid_d;
    logic            ack_bad;
    logic            last;

`ifdef I2C_ACK_CHECK_EN
    assign ack_bad = iSDA;
`else
    assign ack_bad = 1'b0;
`endif

    assign last = (cnt_q == NB_W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            rw_q     <= 1'b0;
            cnt_q    <= '0;
            bit_q    <= '0;
            sh_q     <= '0;
            hold_q   <= '0;
            nack_q   <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rw_q     <= rw_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            sh_q     <= sh_d;
            hold_q   <= hold_d;
            nack_q   <= nack_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rw_d     = rw_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        sh_d     = sh_q;
        hold_d   = hold_q;
        nack_d   = nack_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        oSDA     = 1'b1;
        go       = 1'b0;
        abit     = 1'b0;
        sclEn    = 1'b0;
        wnext    = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    go      = 1'b1;
                    addr_d  = addr;
                    rw_d    = rw;
                    cnt_d   = nbytes;
                    sh_d    = wdata;
                    nack_d  = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                oSDA    = 1'b0;
                bit_d   = 3'd6;
                state_d = S_ADDR;
            end
            S_ADDR: begin
                abit  = 1'b1;
                sclEn = 1'b1;
                oSDA  = auSDA;
                bit_d = bit_q - 3'd1;
                if (bit_q == 3'd0) state_d = S_RW;
            end
            S_RW: begin
                sclEn   = 1'b1;
                oSDA    = rw_q;
                state_d = S_AACK;
            end
            S_AACK: begin
                sclEn  = 1'b1;
                hold_d = '0;
                bit_d  = 3'd7;
                if (ack_bad) begin
                    nack_d  = 1'b1;
                    state_d = S_STOP;
                end else if (cnt_q == '0) begin
                    state_d = S_STOP;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                sclEn = 1'b1;
                if (rw_q) begin
                    sh_d = {sh_q[6:0], iSDA};
                end else begin
                    oSDA = sh_q[7];
                    sh_d = {sh_q[6:0], 1'b0};
                end
                bit_d = bit_q - 3'd1;
                if (bit_q == 3'd0) state_d = S_DACK;
            end
            S_DACK: begin
                sclEn  = 1'b1;
                cnt_d  = cnt_q - 1'b1;
                hold_d = '0;
                bit_d  = 3'd7;
                if (rw_q) begin
                    // Master ACKs every read byte except the last one
                    rdata_d  = sh_q;
                    rvalid_d = 1'b1;
                    oSDA     = last;
                    state_d  = last ? S_STOP : S_DATA;
                end else if (ack_bad) begin
                    nack_d  = 1'b1;
                    state_d = S_STOP;
                end else if (!last) begin
                    wnext   = 1'b1;
                    sh_d    = wdata;
                    state_d = S_DATA;
                end else begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (hold_q == HW'(STOP_HOLD)) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    oSDA   = 1'b0;
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // addrIn is bypassed during the go cycle so AUCLK loads the new address
    assign addrIn = go ? addr : addr_q;
    assign ready  = (state_q == S_IDLE);
    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign nack   = nack_q;

endmodule
